uart_tx_fifo: RTL

//  Buffered UART transmitter (8N1, LSB first) driving the SoC uart_tx_out pin toward the USB/UART client.

---
 rtl/uart_pkg.sv | 9 +
 rtl/sync_fifo.sv | 39 +++
 rtl/uart_tx_fifo.sv | 87 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter types, frame constants and baud divider helper
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;
  function automatic int calc_baud_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered full/empty/count; caller guarantees legal push/pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] nxt;
  assign dout = mem[rd_ptr];
  always_comb nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= nxt;
      full  <= nxt == FULL_CNT;
      empty <= nxt == '0;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter, LSB first, FIFO drained by a bit-timing FSM
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 48_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          Clk,
  input  logic                          Reset_N,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          clr_overflow,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          overflow,
  output logic                          tx_out
);
  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  uart_tx_state_t state;
  logic [BW-1:0] baud_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift, fifo_dout;
  logic baud_last, pop, push;
  assign baud_last = baud_cnt == BAUD_LAST;
  // Popping on the last stop clock chains frames with no idle gap
  assign pop = !empty && (state == IDLE ||
               (state == STOP && baud_last && bit_cnt == 3'(UART_STOP_BITS - 1)));
  assign push = wr_en && (!full || pop);
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(Clk),
    .rst_n(Reset_N),
    .push(push),
    .pop(pop),
    .din(wr_data),
    .dout(fifo_dout),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // tx_out and busy follow the state one clock later, so the line falls two edges after the write
  always_ff @(posedge Clk or negedge Reset_N)
    if (!Reset_N) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      tx_out   <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
      busy     <= state != IDLE;
      overflow <= clr_overflow ? 1'b0 : (wr_en && !push) ? 1'b1 : overflow;
      if (pop) begin
        shift    <= fifo_dout;
        baud_cnt <= '0;
        bit_cnt  <= '0;
        state    <= START;
      end else if (state != IDLE) begin
        baud_cnt <= baud_last ? '0 : baud_cnt + BW'(1);
        if (baud_last)
          case (state)
            START: begin
              state   <= DATA;
              bit_cnt <= '0;
            end
            DATA: begin
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
                state   <= STOP;
                bit_cnt <= '0;
              end
            end
            STOP:
              if (bit_cnt == 3'(UART_STOP_BITS - 1)) state <= IDLE;
              else bit_cnt <= bit_cnt + 3'd1;
            default: state <= IDLE;
          endcase
      end
    end
endmodule
